// File: rtl/aram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aram_pkg
// Purpose : Shared constants, types and the check-bit helper for the 64x544
//           simple-dual-port array buffer and its read sequencer.
// Contents: ARAM_DEPTH / ARAM_AW / ARAM_DW / ARAM_PW constants,
//           aram_ptr_t {wrap,addr} pointer type, aram_entry_t entry type,
//           aram_check_bits() : per-16-bit-lane XOR of the payload.
// Revision: 1.0 - initial release
// ============================================================================
package aram_pkg;

   localparam int ARAM_DEPTH = 64;
   localparam int ARAM_AW    = 6;
   localparam int ARAM_DW    = 544;
   localparam int ARAM_PW    = 7;

   typedef logic [ARAM_PW-1:0] aram_ptr_t;
   typedef logic [ARAM_DW-1:0] aram_entry_t;

   // Bit k of the meta field covers payload lane [16k+15:16k].
   function automatic logic [31:0] aram_check_bits(input aram_entry_t e);
      logic [31:0] c;
      c = '0;
      for (int k = 0; k < 32; k++) begin
         c[k] = ^e[16*k +: 16];
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aram_rd_skid2.sv
`default_nettype none
// ============================================================================
// Module  : aram_rd_skid2
// Purpose : Two-entry registered FIFO that absorbs the array's read latency
//           and presents the head entry as a valid/ready stream.
// Ports   : clock, reset (async, active-high)
//           flush    - empties the FIFO (takes priority over push/pop)
//           push/din - write an entry at the tail
//           pop      - head consumed this cycle (out_valid & ready)
//           cnt      - current fill level 0..2
//           out_valid/out_data - registered head entry
// Revision: 1.0 - initial release
// ============================================================================
module aram_rd_skid2
   import aram_pkg::*;
#(
   parameter int DW = ARAM_DW
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [1:0]    cnt,
   output logic          out_valid,
   output logic [DW-1:0] out_data
);

   logic [DW-1:0] r_head;
   logic [DW-1:0] r_tail;
   logic [1:0]    r_cnt;
   logic          r_valid;
   logic [1:0]    w_cnt_nxt;

   // pop is only ever asserted with r_cnt != 0 and the sequencer never
   // pushes into a full FIFO, so this cannot wrap.
   always_comb begin
      w_cnt_nxt = r_cnt + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt   <= 2'd0;
         r_valid <= 1'b0;
      end else if (flush) begin
         r_cnt   <= 2'd0;
         r_valid <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_valid <= (w_cnt_nxt != 2'd0);
      end
   end

   // Data registers carry no reset: contents are meaningless while empty.
   always_ff @(posedge clock) begin
      case ({push, pop})
         2'b10: begin
            if (r_cnt == 2'd0) r_head <= din;
            else               r_tail <= din;
         end
         2'b01: begin
            r_head <= r_tail;
         end
         2'b11: begin
            if (r_cnt == 2'd1) begin
               r_head <= din;
            end else begin
               r_head <= r_tail;
               r_tail <= din;
            end
         end
         default: begin
         end
      endcase
   end

   assign cnt       = r_cnt;
   assign out_valid = r_valid;
   assign out_data  = r_head;

endmodule
`default_nettype wire

// File: rtl/aram_rd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : aram_rd_sequencer
// Purpose : Read-side sequencer for the 64x544 circular array buffer. Issues
//           array reads while unread entries exist and downstream room allows,
//           absorbs the 1-cycle read latency in a 2-entry skid and streams the
//           entries out in order. rd_ptr goes back to the writer for full
//           detection.
// Ports   : clock/reset (async, active-high)
//           wr_ptr    in  {wrap,addr} from writer
//           flush     in  drop unread and in-flight entries
//           rd_ptr    out {wrap,addr}, registered
//           occupancy out wr_ptr - rd_ptr (0..64)
//           enb/addrb out array read port; dob in read data (next cycle)
//           out_valid/out_ready/out_data  output stream
//           parity_err out sticky check error (only with ARAM_RD_PARITY_EN)
// Config  : `define ARAM_RD_PARITY_EN enables the meta-field lane checker.
// Revision: 1.0 - initial release
// ============================================================================
module aram_rd_sequencer
   import aram_pkg::*;
(
   input  logic [0:0]         clock,
   input  logic               reset,
   input  logic [ARAM_PW-1:0] wr_ptr,
   input  logic               flush,
   output logic [ARAM_PW-1:0] rd_ptr,
   output logic [ARAM_PW-1:0] occupancy,
   output logic               enb,
   output logic [ARAM_AW-1:0] addrb,
   input  logic [ARAM_DW-1:0] dob,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ARAM_DW-1:0] out_data
`ifdef ARAM_RD_PARITY_EN
   ,
   output logic               parity_err
`endif
);

   aram_ptr_t  r_rd_ptr;
   logic       r_inflight;
   logic       w_avail;
   logic       w_pop;
   logic       w_push;
   logic       w_issue;
   logic [1:0] w_skid_cnt;
   logic [2:0] w_load;

   assign w_avail = (wr_ptr != r_rd_ptr);
   assign w_pop   = out_valid & out_ready;
   // The read issued last cycle lands this cycle, unless a flush drops it.
   assign w_push  = r_inflight & ~flush;

   // Entries that will be held downstream after this cycle if nothing new
   // is issued; a new read is allowed only while that stays below two.
   always_comb begin
      w_load  = {1'b0, w_skid_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
      w_issue = w_avail & ~flush & (w_load < 3'd2);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_rd_ptr <= wr_ptr;
      end else if (w_issue) begin
         r_rd_ptr <= r_rd_ptr + 7'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
      end
   end

   aram_rd_skid2 #(
      .DW (ARAM_DW)
   ) u_skid (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .push      (w_push),
      .din       (dob),
      .pop       (w_pop),
      .cnt       (w_skid_cnt),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   assign rd_ptr    = r_rd_ptr;
   assign occupancy = wr_ptr - r_rd_ptr;
   assign enb       = w_issue;
   assign addrb     = r_rd_ptr[ARAM_AW-1:0];

`ifdef ARAM_RD_PARITY_EN
   logic r_parity_err;
   logic w_chk_bad;

   // Only entries actually captured into the skid are judged.
   assign w_chk_bad = (aram_check_bits(dob) != dob[ARAM_DW-1:512]);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_parity_err <= 1'b0;
      end else if (w_push & w_chk_bad) begin
         r_parity_err <= 1'b1;
      end
   end

   assign parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aram_rd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_aram_rd_sequencer
// Purpose : Scoreboard bench for aram_rd_sequencer with a behavioural array
//           and writer. Written entries are queued as expected beats; a
//           negedge monitor checks every presented beat, every read issue
//           and the occupancy against a simple pointer/count model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aram_rd_sequencer;
   import aram_pkg::*;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [6:0]   wr_ptr = 7'd0;
   logic         flush = 1'b0;
   logic [6:0]   rd_ptr;
   logic [6:0]   occupancy;
   logic         enb;
   logic [5:0]   addrb;
   logic [543:0] dob;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [543:0] out_data;
`ifdef ARAM_RD_PARITY_EN
   logic         parity_err;
`endif

   aram_rd_sequencer dut (
      .clock      (clock),
      .reset      (reset),
      .wr_ptr     (wr_ptr),
      .flush      (flush),
      .rd_ptr     (rd_ptr),
      .occupancy  (occupancy),
      .enb        (enb),
      .addrb      (addrb),
      .dob        (dob),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data)
`ifdef ARAM_RD_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   always #5 clock = ~clock;

   // Behavioural array: registered read port.
   logic [543:0] mem [0:63];
   always @(posedge clock) begin
      if (enb) dob <= mem[addrb];
   end

   int           n_vec = 0;
   int           n_err = 0;
   logic [543:0] exp_q[$];
   logic [6:0]   model_rd = 7'd0;
   int           outstanding = 0;
   bit           rand_ready = 1'b0;

   task automatic chk(input string nm, input logic [543:0] act, input logic [543:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [543:0] make_entry();
      logic [543:0] e;
      e = '0;
      for (int i = 0; i < 16; i++) e[32*i +: 32] = $urandom;
      e[543:512] = aram_check_bits(e);
      return e;
   endfunction

   // Writer: fills entries then advances its pointer.
   task automatic write_n(input int n, input int bad_idx);
      logic [543:0] e;
      for (int i = 0; i < n; i++) begin
         e = make_entry();
         if (i == bad_idx) e[5] = ~e[5];
         mem[wr_ptr[5:0]] = e;
         exp_q.push_back(e);
         wr_ptr = wr_ptr + 7'd1;
      end
   endtask

   task automatic do_flush(input logic [6:0] nw);
      flush  = 1'b1;
      wr_ptr = nw;
      tick();
      flush = 1'b0;
      exp_q.delete();
      model_rd    = nw;
      outstanding = 0;
      chk("flush_out_valid", out_valid, 0);
      chk("flush_rd_ptr", rd_ptr, nw);
   endtask

   task automatic drain(input int budget);
      int c;
      c = 0;
      while ((exp_q.size() != 0 || out_valid || rd_ptr != wr_ptr) && c < budget) begin
         tick();
         c++;
      end
      if (c >= budget) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: got %0d beats left expected 0", exp_q.size());
      end
      chk("drain_rd_ptr", rd_ptr, wr_ptr);
      chk("drain_occupancy", occupancy, 0);
   endtask

   // Monitor / scoreboard.
   always @(negedge clock) begin
      logic [6:0] eo;
      int         p;
      if (!reset) begin
         eo = wr_ptr - model_rd;
         p  = (out_valid && out_ready) ? 1 : 0;
         chk("occupancy", occupancy, eo);
         if (enb) begin
            chk("enb_during_flush", flush, 0);
            chk("addrb", addrb, model_rd[5:0]);
            chk("enb_when_empty", (wr_ptr != model_rd), 1);
            chk("enb_depth", ((outstanding - p) < 2), 1);
            model_rd = model_rd + 7'd1;
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL stale_beat: got %0h expected no beat", out_data);
            end else begin
               chk("out_data", out_data, exp_q[0]);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         outstanding = outstanding + (enb ? 1 : 0) - p;
      end
   end

   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] d;
      int         w;
      int         k;
      int         r;

      repeat (3) tick();
      chk("rst_rd_ptr", rd_ptr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_enb", enb, 0);
      chk("rst_occupancy", occupancy, 0);
      reset = 1'b0;
      tick();

      // First-entry latency.
      out_ready = 1'b1;
      write_n(1, -1);
      @(negedge clock);
      chk("t1_enb", enb, 1);
      chk("t1_addrb", addrb, 0);
      @(negedge clock);
      chk("t1_valid_c1", out_valid, 0);
      @(negedge clock);
      chk("t1_valid_c2", out_valid, 1);
      tick();
      drain(20);

      // Full buffer at one beat per cycle.
      do_flush(7'h00);
      write_n(64, -1);
      @(negedge clock);
      chk("t2_occ64", occupancy, 64);
      w = 0;
      while (!out_valid && w < 10) begin
         @(negedge clock);
         w++;
      end
      chk("t2_first_beat", out_valid, 1);
      for (int i = 1; i < 64; i++) begin
         @(negedge clock);
         chk("t2_consecutive", out_valid, 1);
      end
      @(negedge clock);
      chk("t2_done", out_valid, 0);
      tick();
      chk("t2_rd_ptr", rd_ptr, 7'h40);
      drain(20);

      // Full buffer with random back-pressure.
      write_n(64, -1);
      rand_ready = 1'b1;
      drain(1000);
      rand_ready = 1'b0;
      tick();
      out_ready = 1'b1;

      // Stream across the wrap point.
      do_flush(7'h7E);
      write_n(4, -1);
      drain(30);
      chk("t4_rd_ptr", rd_ptr, 7'h02);
      chk("t4_wrap_bit", rd_ptr[6], 0);

      // Flush with a full skid and a coinciding pop.
      out_ready = 1'b0;
      write_n(8, -1);
      repeat (4) tick();
      chk("t5_skid_held", out_valid, 1);
      out_ready = 1'b1;
      do_flush(7'h30);
      write_n(3, -1);
      drain(30);

      // Flush mid-stream with a read in flight.
      write_n(8, -1);
      repeat (2) tick();
      do_flush(wr_ptr);
      write_n(2, -1);
      drain(30);

      // Random traffic with occasional flushes.
      rand_ready = 1'b1;
      for (int it = 0; it < 400; it++) begin
         tick();
         r = $urandom_range(0, 19);
         if (r == 0) begin
            do_flush(wr_ptr);
         end else if (r < 8) begin
            k = $urandom_range(1, 4);
            d = wr_ptr - rd_ptr;
            if (int'(d) + k <= 64) write_n(k, -1);
         end
      end
      rand_ready = 1'b0;
      tick();
      out_ready = 1'b1;
      drain(300);

      // Reset in mid-operation (writer shares the reset net).
      write_n(10, -1);
      repeat (3) tick();
      reset  = 1'b1;
      wr_ptr = 7'd0;
      exp_q.delete();
      model_rd    = 7'd0;
      outstanding = 0;
      #1;
      chk("t7_async_rd_ptr", rd_ptr, 0);
      chk("t7_async_valid", out_valid, 0);
      tick();
      reset = 1'b0;
      tick();
      write_n(5, -1);
      drain(30);

`ifdef ARAM_RD_PARITY_EN
      chk("par_clean", parity_err, 0);
      write_n(3, 1);
      drain(30);
      chk("par_set", parity_err, 1);
      repeat (5) tick();
      chk("par_sticky", parity_err, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
